// File: rtl/serial_rx_a_pkg.sv
// Shared definitions for the serial receive path.
// State encoding and default frame geometry.
package serial_rx_a_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/sync2_a.sv
// Two-flop synchronizer for a single asynchronous input.
// Both stages load RST_VAL while reset is low.
module sync2_a #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_a.sv
// Serial frame receiver: start, DATA_W bits LSB first, stop.
// Emits a one-cycle valid or frame_err strobe per frame.
module serial_rx_a
  import serial_rx_a_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] TOP  = BW'(DATA_W - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] sh_next;
  logic              rx_s;

  sync2_a #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rxd),
    .q    (rx_s)
  );

  // New sample enters at the MSB so the first bit lands in bit 0
  if (DATA_W == 1) begin : g_sh1
    assign sh_next = rx_s;
  end else begin : g_shn
    assign sh_next = {rx_s, shift[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == MID) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shift <= sh_next;
            if (bit_cnt == TOP) begin
              state <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data  <= shift;
              valid <= 1'b1;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Held-low line: one error only, wait for the line to recover
        ST_BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
